iob_regfile_scanner: RTL

Read-side consumer for the clock-domain-crossing register file. It continuously sweeps every address of the register file's read port and keeps a shadow copy of the last value seen at each address. When an entry's value differs from its shadow copy, it emits a change event (address plus new value) over a valid/ready stream. It sits in the read clock domain, between the register file and event logging/interrupt logic.

---
 rtl/iob_regfile_scanner.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/iob_regfile_scanner.sv
// ----------------------------------------------------------------------------
// iob_regfile_scanner
//
// Read-side consumer of the clock-domain-crossing register file. It sweeps
// every address of the register file read port, keeps a shadow copy of the
// last value seen at each address, and emits a change event (address + new
// value) whenever an entry differs from its shadow copy.
//
// Ports
//   clk_i        read clock of the register file
//   arst_n_i     asynchronous active-low reset
//   en_i         scan enable, level-sensitive
//   r_en_o       register file read-port synchronizer enable (high unless IDLE)
//   r_addr_o     read address presented to the register file
//   r_data_i     read data, combinational function of r_addr_o
//   ev_valid_o   change event valid
//   ev_ready_i   change event accepted by the consumer
//   ev_addr_o    address of the changed entry
//   ev_data_o    new value of the changed entry
//   pass_o       one-cycle pulse after the address wraps to 0
//   busy_o       high in SCAN and EMIT
//   ev_cnt_o     accepted events, saturating at 16'hFFFF
//   dbg_state_o  current FSM state (0 IDLE, 1 SCAN, 2 EMIT)
//
// Event stream handshake: an event transfers on a rising clock edge where
// ev_valid_o and ev_ready_i are both 1. Once ev_valid_o rises, ev_valid_o,
// ev_addr_o and ev_data_o hold until that transfer; ev_valid_o never drops
// without a transfer except under reset. ev_ready_i may change freely.
// ----------------------------------------------------------------------------
module iob_regfile_scanner #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              en_i,
    output logic              r_en_o,
    output logic [ADDR_W-1:0] r_addr_o,
    input  logic [DATA_W-1:0] r_data_i,
    output logic              ev_valid_o,
    input  logic              ev_ready_i,
    output logic [ADDR_W-1:0] ev_addr_o,
    output logic [DATA_W-1:0] ev_data_o,
    output logic              pass_o,
    output logic              busy_o,
    output logic [15:0]       ev_cnt_o,
    output logic [1:0]        dbg_state_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and next-state signals
    // ------------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                ev_valid_q, ev_valid_d;
    logic [ADDR_W-1:0]   ev_addr_q, ev_addr_d;
    logic [DATA_W-1:0]   ev_data_q, ev_data_d;
    logic                pass_q, pass_d;
    logic                busy_q, busy_d;
    logic                ren_q, ren_d;
    logic [15:0]         cnt_q, cnt_d;

    logic [DATA_W-1:0]   shadow_q [DEPTH];
    logic                shadow_we;

    logic                mismatch;
    logic                advance;

    // The read data belongs to the address presented this cycle, so the
    // comparison against the shadow copy is purely combinational.
    assign mismatch = (r_data_i != shadow_q[addr_q]);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ev_valid_d = ev_valid_q;
        ev_addr_d  = ev_addr_q;
        ev_data_d  = ev_data_q;
        cnt_d      = cnt_q;
        pass_d     = 1'b0;
        shadow_we  = 1'b0;
        advance    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Resume where the last sweep stopped; the address is kept.
                if (en_i) begin
                    state_d = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (mismatch) begin
                    // Capture the event and update the shadow in the same
                    // edge; the address stays put until the event is taken.
                    ev_addr_d  = addr_q;
                    ev_data_d  = r_data_i;
                    ev_valid_d = 1'b1;
                    shadow_we  = 1'b1;
                    state_d    = ST_EMIT;
                end else if (en_i) begin
                    advance = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_EMIT: begin
                // en_i is only consulted after the transfer, so a pending
                // event is never dropped by disabling the scanner.
                if (ev_valid_q && ev_ready_i) begin
                    ev_valid_d = 1'b0;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    advance = 1'b1;
                    state_d = en_i ? ST_SCAN : ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Single place for the address step, shared by SCAN and EMIT, so the
        // wrap pulse is produced identically from either state.
        if (advance) begin
            addr_d = addr_q + ADDR_W'(1);
            pass_d = (addr_q == ADDR_MAX);
        end

        busy_d = (state_d != ST_IDLE);
        ren_d  = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------------
    // FSM and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            ev_valid_q <= 1'b0;
            ev_addr_q  <= '0;
            ev_data_q  <= '0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b0;
            ren_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ev_valid_q <= ev_valid_d;
            ev_addr_q  <= ev_addr_d;
            ev_data_q  <= ev_data_d;
            pass_q     <= pass_d;
            busy_q     <= busy_d;
            ren_q      <= ren_d;
            cnt_q      <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Shadow storage: cleared by reset so the first sweep reports every
    // nonzero entry; written only when an event is captured.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (shadow_we) begin
            shadow_q[addr_q] <= r_data_i;
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign r_en_o      = ren_q;
    assign r_addr_o    = addr_q;
    assign ev_valid_o  = ev_valid_q;
    assign ev_addr_o   = ev_addr_q;
    assign ev_data_o   = ev_data_q;
    assign pass_o      = pass_q;
    assign busy_o      = busy_q;
    assign ev_cnt_o    = cnt_q;
    assign dbg_state_o = state_q;

endmodule
